// File: rtl/digit_rec_pkg.sv
// Shared definitions for the digit recognition datapath: bank geometry,
// input sum width and the sigmoid register bank state encoding.
package digit_rec_pkg;

    localparam int NUM_DIGITS = 10;
    localparam int CONF_WIDTH = 4;
    localparam int SUM_WIDTH  = 16;
    localparam int IDX_WIDTH  = 4;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_COST = 2'd2
    } bank_state_t;

endpackage

// File: rtl/sigmoid_quantizer.sv
// Combinational sigmoid approximation: arithmetic right shift of the neuron
// sum, offset by mid-scale, clamped to the 4-bit confidence range.
// Ports:
//   sum_i  - signed neuron sum
//   conf_o - confidence 0..15
module sigmoid_quantizer
    import digit_rec_pkg::*;
#(
    parameter int SHIFT = 8
) (
    input  logic signed [SUM_WIDTH-1:0]  sum_i,
    output logic        [CONF_WIDTH-1:0] conf_o
);

    // One extra bit of headroom so the +8 offset can never wrap.
    logic signed [SUM_WIDTH:0] ext;
    logic signed [SUM_WIDTH:0] shifted;
    logic signed [SUM_WIDTH:0] biased;

    assign ext     = {sum_i[SUM_WIDTH-1], sum_i};
    assign shifted = ext >>> SHIFT;
    assign biased  = shifted + 17'sd8;

    always_comb begin
        if (biased < 17'sd0) begin
            conf_o = '0;
        end else if (biased > 17'sd15) begin
            conf_o = '1;
        end else begin
            conf_o = biased[CONF_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/sigmoid_register_bank.sv
// Collects the ten output-neuron sums, quantises each to a 4-bit confidence
// and holds them as a stable bank for the cost calculator. Once every digit
// has been written the bank launches the calculator with a single cost_en
// pulse, latches the arg-max digit, and stays frozen until the calculator
// reports calculation_complete.
//
// state     | meaning
// FILL      | accepting sums until every index has been written
// LAUNCH    | cost_en high, arg-max latched at the end of this cycle
// WAIT_COST | bank frozen, inputs ignored until calculation_complete
//
// Ports:
//   clk, n_rst             - clock, async active-low reset
//   sum_valid/index/value  - incoming neuron sum, accepted when sum_ready
//   sum_ready              - high only while filling
//   calculation_complete   - one-cycle pulse from the cost calculator
//   cost_en                - one-cycle launch pulse
//   digit_weights          - registered confidence bank
//   best_digit             - arg-max index, lowest index wins ties
//   index_error            - sticky flag for accepted index > 9
module sigmoid_register_bank
    import digit_rec_pkg::*;
#(
    parameter int SHIFT = 8
) (
    input  logic                                   clk,
    input  logic                                   n_rst,
    input  logic                                   sum_valid,
    input  logic [IDX_WIDTH-1:0]                   sum_index,
    input  logic signed [SUM_WIDTH-1:0]            sum_value,
    output logic                                   sum_ready,
    input  logic                                   calculation_complete,
    output logic                                   cost_en,
    output logic [0:NUM_DIGITS-1][CONF_WIDTH-1:0]  digit_weights,
    output logic [IDX_WIDTH-1:0]                   best_digit,
    output logic                                   index_error
);

    bank_state_t                              state_q;
    logic [NUM_DIGITS-1:0]                    filled_q;
    logic [NUM_DIGITS-1:0]                    filled_d;
    logic [0:NUM_DIGITS-1][CONF_WIDTH-1:0]    weights_q;
    logic [IDX_WIDTH-1:0]                     best_q;
    logic                                     cost_en_q;
    logic                                     index_error_q;

    logic [CONF_WIDTH-1:0]                    conf;
    logic                                     idx_legal;
    logic [IDX_WIDTH-1:0]                     argmax_idx;
    logic [CONF_WIDTH-1:0]                    argmax_val;

    sigmoid_quantizer #(.SHIFT(SHIFT)) u_quant (
        .sum_i  (sum_value),
        .conf_o (conf)
    );

    assign sum_ready = (state_q == FILL);
    assign idx_legal = (sum_index < IDX_WIDTH'(NUM_DIGITS));
    assign filled_d  = filled_q | ({{(NUM_DIGITS-1){1'b0}}, 1'b1} << sum_index);

    // Strict greater-than keeps the earliest index on ties.
    always_comb begin
        argmax_idx = '0;
        argmax_val = weights_q[0];
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (weights_q[i] > argmax_val) begin
                argmax_val = weights_q[i];
                argmax_idx = IDX_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= FILL;
            filled_q      <= '0;
            weights_q     <= '0;
            best_q        <= '0;
            cost_en_q     <= 1'b0;
            index_error_q <= 1'b0;
        end else begin
            cost_en_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (sum_valid) begin
                        if (idx_legal) begin
                            weights_q[sum_index] <= conf;
                            filled_q             <= filled_d;
                            if (&filled_d) begin
                                state_q   <= LAUNCH;
                                cost_en_q <= 1'b1;
                            end
                        end else begin
                            index_error_q <= 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    best_q  <= argmax_idx;
                    state_q <= WAIT_COST;
                end
                WAIT_COST: begin
                    if (calculation_complete) begin
                        filled_q <= '0;
                        state_q  <= FILL;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign cost_en       = cost_en_q;
    assign digit_weights = weights_q;
    assign best_digit    = best_q;
    assign index_error   = index_error_q;

endmodule

// File: tb/tb_sigmoid_register_bank.sv
module tb_sigmoid_register_bank;

    logic                 clk;
    logic                 n_rst;
    logic                 sum_valid;
    logic [3:0]           sum_index;
    logic [15:0]          sum_value;
    logic                 sum_ready;
    logic                 calculation_complete;
    logic                 cost_en;
    logic [0:9][3:0]      digit_weights;
    logic [3:0]           best_digit;
    logic                 index_error;

    int n_pass  = 0;
    int n_total = 0;
    int cost_cnt = 0;

    sigmoid_register_bank #(.SHIFT(8)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .sum_valid            (sum_valid),
        .sum_index            (sum_index),
        .sum_value            (sum_value),
        .sum_ready            (sum_ready),
        .calculation_complete (calculation_complete),
        .cost_en              (cost_en),
        .digit_weights        (digit_weights),
        .best_digit           (best_digit),
        .index_error          (index_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (cost_en === 1'b1) cost_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic xfer(input logic [3:0] idx, input logic [15:0] val);
        sum_valid = 1'b1;
        sum_index = idx;
        sum_value = val;
        @(posedge clk);
        #1;
        sum_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] val;
        logic [3:0]  exp;
    } qvec_t;

    qvec_t qv[7];
    logic [0:9][3:0] exp_w;
    int snap;

    initial begin
        qv[0] = '{16'h0000, 4'd8};
        qv[1] = '{16'h0700, 4'd15};
        qv[2] = '{16'h0100, 4'd9};
        qv[3] = '{16'hF700, 4'd0};
        qv[4] = '{16'h7FFF, 4'd15};
        qv[5] = '{16'h8000, 4'd0};
        qv[6] = '{16'hFF80, 4'd7};

        n_rst = 1'b0;
        sum_valid = 1'b0;
        sum_index = '0;
        sum_value = '0;
        calculation_complete = 1'b0;

        // reset values
        @(negedge clk);
        chk("rst_weights", 64'(digit_weights), 64'h0);
        chk("rst_best", 64'(best_digit), 64'h0);
        chk("rst_cost_en", 64'(cost_en), 64'h0);
        chk("rst_index_error", 64'(index_error), 64'h0);
        @(posedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        chk("rst_sum_ready", 64'(sum_ready), 64'h1);

        // quantiser sweep through entry 0 (duplicate index, never launches)
        for (int i = 0; i < 7; i++) begin
            xfer(4'd0, qv[i].val);
            @(negedge clk);
            chk($sformatf("quant_%0d", i), 64'(digit_weights[0]), 64'(qv[i].exp));
        end
        chk("quant_no_launch", 64'(cost_cnt), 64'h0);

        // back-to-back in-order fill
        n_rst = 1'b0;
        #1 n_rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) xfer(4'(i), 16'(i * 16'h0100));
        @(negedge clk);
        exp_w = {4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd15, 4'd15};
        chk("fill_cost_en", 64'(cost_en), 64'h1);
        chk("fill_sum_ready_low", 64'(sum_ready), 64'h0);
        chk("fill_weights", 64'(digit_weights), 64'(exp_w));
        idle(1);
        @(negedge clk);
        chk("fill_cost_en_single", 64'(cost_en), 64'h0);
        chk("fill_cost_cnt", 64'(cost_cnt), 64'd1);
        chk("fill_best", 64'(best_digit), 64'd7);

        // inputs ignored in WAIT_COST
        sum_valid = 1'b1;
        sum_index = 4'd0;
        sum_value = 16'h8000;
        idle(3);
        sum_valid = 1'b0;
        @(negedge clk);
        chk("wait_weights_frozen", 64'(digit_weights), 64'(exp_w));
        chk("wait_sum_ready", 64'(sum_ready), 64'h0);
        chk("wait_no_relaunch", 64'(cost_cnt), 64'd1);

        calculation_complete = 1'b1;
        idle(1);
        calculation_complete = 1'b0;
        @(negedge clk);
        chk("done_sum_ready", 64'(sum_ready), 64'h1);
        chk("done_weights_kept", 64'(digit_weights), 64'(exp_w));
        chk("done_best_kept", 64'(best_digit), 64'd7);

        // duplicate index, illegal index and early complete during fill
        xfer(4'd3, 16'h0000);
        for (int i = 0; i < 9; i++) if (i != 3) xfer(4'(i), 16'h0000);
        xfer(4'd3, 16'h0300);
        xfer(4'd12, 16'h7FFF);
        calculation_complete = 1'b1;
        idle(1);
        calculation_complete = 1'b0;
        @(negedge clk);
        chk("dup_no_launch", 64'(cost_cnt), 64'd1);
        chk("dup_sum_ready", 64'(sum_ready), 64'h1);
        chk("idx_err_set", 64'(index_error), 64'h1);
        exp_w = {4'd8, 4'd8, 4'd8, 4'd11, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd15};
        chk("idx_err_bank", 64'(digit_weights), 64'(exp_w));
        xfer(4'd9, 16'h0000);
        @(negedge clk);
        exp_w[9] = 4'd8;
        chk("dup_launch", 64'(cost_en), 64'h1);
        chk("dup_weights", 64'(digit_weights), 64'(exp_w));
        idle(1);
        @(negedge clk);
        chk("dup_best", 64'(best_digit), 64'd3);
        chk("idx_err_sticky", 64'(index_error), 64'h1);

        // reset in WAIT_COST
        snap = cost_cnt;
        n_rst = 1'b0;
        @(negedge clk);
        chk("midrst_weights", 64'(digit_weights), 64'h0);
        chk("midrst_best", 64'(best_digit), 64'h0);
        chk("midrst_cost_en", 64'(cost_en), 64'h0);
        chk("midrst_index_error", 64'(index_error), 64'h0);
        @(posedge clk);
        #1 n_rst = 1'b1;
        idle(3);
        @(negedge clk);
        chk("midrst_sum_ready", 64'(sum_ready), 64'h1);
        chk("midrst_no_cost_en", 64'(cost_cnt), 64'(snap));

        // all-equal bank: tie goes to index 0
        for (int i = 9; i >= 0; i--) xfer(4'(i), 16'h0500);
        idle(1);
        @(negedge clk);
        chk("tie_launched", 64'(cost_cnt), 64'(snap + 1));
        chk("tie_best", 64'(best_digit), 64'd0);
        chk("tie_weights", 64'(digit_weights), 64'hDDDD_DDDD_DD);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
